// File: rtl/seg_pkg.sv
// seg_pkg: shared widths, blank pattern and slot state encoding for the seven-segment scan driver.
package seg_pkg;
    localparam int SEG_W    = 7;
    localparam int BRIGHT_W = 4;
    localparam int SUBSLOTS = 16;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;
    typedef enum logic [1:0] {DEAD, ON, OFF} state_t;
endpackage

// File: rtl/scan_timebase.sv
// scan_timebase: nested sub_cnt / sub_idx / digit_idx counters that define the frame position.
module scan_timebase
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SUB_CYCLES = 64,
    parameter int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [3:0]    sub_idx,
    output logic [DW-1:0] digit_idx,
    output logic          frame_start,
    output logic          frame_end
);
    localparam int CW = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    logic [CW-1:0] sub_cnt;
    logic sub_last, idx_last, dig_last;
    always_comb begin
        sub_last    = sub_cnt == CW'(SUB_CYCLES - 1);
        idx_last    = sub_idx == 4'(SUBSLOTS - 1);
        dig_last    = digit_idx == DW'(NUM_DIGITS - 1);
        frame_start = sub_cnt == '0 && sub_idx == '0 && digit_idx == '0;
        frame_end   = sub_last && idx_last && dig_last;
    end
    // Counters hold the position of the upcoming edge, so outputs registered at that edge see it directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt   <= '0;
            sub_idx   <= '0;
            digit_idx <= '0;
        end else begin
            sub_cnt <= sub_last ? '0 : sub_cnt + 1'b1;
            if (sub_last) begin
                sub_idx <= idx_last ? '0 : sub_idx + 4'd1;
                if (idx_last)
                    digit_idx <= dig_last ? '0 : digit_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment driver with per-slot dead time, 16-level PWM
// and frame-coherent snapshots of the segment patterns and brightness.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SUB_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
    input  logic [BRIGHT_W-1:0]         brightness,
    input  logic                        blank,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_en,
    output logic                        frame_done
);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    logic [3:0] sub_idx;
    logic [DW-1:0] digit_idx;
    logic frame_start, frame_end, on;
    logic [SEG_W*NUM_DIGITS-1:0] seg_snap;
    logic [BRIGHT_W-1:0] b_snap;
    logic [SEG_W-1:0] cur_seg;
    state_t state, nxt;

    scan_timebase #(.NUM_DIGITS(NUM_DIGITS), .SUB_CYCLES(SUB_CYCLES), .DW(DW)) u_tb (
        .clk(clk), .rst(rst), .sub_idx(sub_idx), .digit_idx(digit_idx),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    // The snapshot written at frame start is only read from sub_idx 1 on; the DEAD sub-slot hides the update.
    always_comb begin
        nxt = sub_idx == '0 ? DEAD :
              state == DEAD ? (b_snap != '0 ? ON : OFF) :
              (state == ON && sub_idx > b_snap) ? OFF : state;
        on      = nxt == ON && !blank;
        cur_seg = seg_snap[digit_idx*SEG_W +: SEG_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DEAD;
            seg_snap   <= '0;
            b_snap     <= '0;
            seg_out    <= SEG_BLANK;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (frame_start) begin
                seg_snap <= seg_in;
                b_snap   <= brightness;
            end
            state      <= nxt;
            dig_en     <= on ? NUM_DIGITS'(1) << digit_idx : '0;
            seg_out    <= on ? cur_seg : SEG_BLANK;
            frame_done <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random stimulus checked against a position-arithmetic model.
module tb_seg_scan_driver;
    localparam int ND = 2, SC = 4, SLOT = 16 * SC, FRAME = ND * SLOT;
    logic clk = 0, rst = 1, blank = 0;
    logic [7*ND-1:0] seg_in = '0;
    logic [3:0] brightness = '0;
    logic [6:0] seg_out;
    logic [ND-1:0] dig_en;
    logic frame_done;
    int errors = 0, checks = 0, p = 0, snap_b = 0;
    logic [7*ND-1:0] snap_seg = '0;
    logic [31:0] exp_en, exp_seg, exp_fd;

    seg_scan_driver #(.NUM_DIGITS(ND), .SUB_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .brightness(brightness), .blank(blank),
        .seg_out(seg_out), .dig_en(dig_en), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s pos=%0d got=%0h exp=%0h", tag, p, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("dig_en", 32'(dig_en), exp_en);
        check("seg_out", 32'(seg_out), exp_seg);
        check("frame_done", 32'(frame_done), exp_fd);
        check("onehot", 32'($countones(dig_en) <= 1), 1);
        check("seg_idle", 32'(dig_en == '0 && seg_out != '0), 0);
    endtask

    task automatic step();
        int slot, sub;
        bit lit;
        @(posedge clk);
        if (rst) begin
            exp_en = 0; exp_seg = 0; exp_fd = 0;
        end else begin
            if (p % FRAME == 0) begin
                snap_seg = seg_in;
                snap_b   = brightness;
            end
            slot = (p % FRAME) / SLOT;
            sub  = (p / SC) % 16;
            lit  = sub >= 1 && sub <= snap_b && !blank;
            exp_en  = lit ? 32'(1) << slot : 0;
            exp_seg = lit ? 32'(snap_seg[slot*7 +: 7]) : 0;
            exp_fd  = 32'(p % FRAME == FRAME - 1);
            p++;
        end
        #1 check_outputs();
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        exp_en = 0; exp_seg = 0; exp_fd = 0;
        check_outputs();
        p = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic run_to(input int pos);
        while (p % FRAME != pos) step();
    endtask

    initial begin
        #2;
        exp_en = 0; exp_seg = 0; exp_fd = 0;
        check_outputs();
        seg_in = {7'b0000110, 7'b0111111};
        brightness = 15;
        step();
        step();
        rst = 0;
        p = 0;
        repeat (FRAME) step();
        brightness = 3;
        repeat (2 * FRAME) step();
        brightness = 0;
        repeat (FRAME) step();
        brightness = 15;
        run_to(70);
        seg_in = {7'b1011011, 7'b1001111};
        repeat (FRAME + 10) step();
        run_to(21);
        blank = 1;
        run_to(31);
        blank = 0;
        run_to(91);
        #2;
        async_reset();
        repeat (FRAME) step();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) seg_in = 14'($urandom);
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom);
            if ($urandom_range(0, 19) == 0) blank = ~blank;
            if ($urandom_range(0, 999) == 0) async_reset();
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
